// File: rtl/branch_unit_pkg.sv
// Shared encodings for the branch unit: condition codes, FSM states and flag bit positions.
// Imported by the top and by the condition evaluator.
package branch_unit_pkg;

    localparam int COND_W = 3;
    localparam int FLAG_W = 2;

    localparam logic [COND_W-1:0] COND_JMP = 3'b000;
    localparam logic [COND_W-1:0] COND_JZ  = 3'b001;
    localparam logic [COND_W-1:0] COND_JNZ = 3'b010;
    localparam logic [COND_W-1:0] COND_JC  = 3'b011;
    localparam logic [COND_W-1:0] COND_JNC = 3'b100;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_HALT    = 2'd2
    } state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational jump-condition decoder: (cond, flags) -> (taken, illegal).
// Zero latency; no flow control.
module branch_cond_eval
    import branch_unit_pkg::*;
(
    input  logic [COND_W-1:0] i_cond,
    input  logic [FLAG_W-1:0] i_flags,
    output logic              o_taken,
    output logic              o_illegal
);

    always_comb begin
        o_taken   = 1'b0;
        o_illegal = 1'b0;
        case (i_cond)
            COND_JMP: o_taken = 1'b1;
            COND_JZ:  o_taken = i_flags[FLAG_Z];
            COND_JNZ: o_taken = ~i_flags[FLAG_Z];
            COND_JC:  o_taken = i_flags[FLAG_C];
            COND_JNC: o_taken = ~i_flags[FLAG_C];
            default:  o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Program counter with two-cycle conditional jump resolution against captured ALU flags.
// Jump result visible two edges after the request; busy stalls the sequencer in RESOLVE/HALT.
module branch_unit
    import branch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pc_en,
    input  logic              i_jump_req,
    input  logic [COND_W-1:0] i_jump_cond,
    input  logic [ADDR_W-1:0] i_jump_target,
    input  logic [FLAG_W-1:0] i_flags,
    input  logic              i_flag_write,
    input  logic [FLAG_W-1:0] i_flag_in,
    input  logic              i_halt,
    output logic [ADDR_W-1:0] o_pc_out,
    output logic              o_jump_taken,
    output logic              o_cond_err,
    output logic              o_busy
);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [COND_W-1:0]   r_cond;
    logic [ADDR_W-1:0]   r_target;
    logic [FLAG_W-1:0]   r_flags;
    logic                r_jump_taken;
    logic                r_cond_err;

    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic                w_capture;
    logic                w_taken_nxt;
    logic                w_err_nxt;
    logic [FLAG_W-1:0]   w_eff_flags;
    logic                w_taken;
    logic                w_illegal;

    // A flag write in the request cycle must be seen by the jump it accompanies.
    assign w_eff_flags = i_flag_write ? i_flag_in : i_flags;

    branch_cond_eval u_cond_eval (
        .i_cond    (r_cond),
        .i_flags   (r_flags),
        .o_taken   (w_taken),
        .o_illegal (w_illegal)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_capture   = 1'b0;
        w_taken_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (i_halt) begin
                    w_state_nxt = ST_HALT;
                end else if (i_jump_req) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESOLVE;
                end else if (i_pc_en) begin
                    w_pc_nxt = r_pc + ADDR_W'(1);
                end
            end
            ST_RESOLVE: begin
                // Not-taken leaves PC alone: the sequencer already stepped past the jump word.
                if (w_taken) begin
                    w_pc_nxt    = r_target;
                    w_taken_nxt = 1'b1;
                end
                w_err_nxt   = w_illegal;
                w_state_nxt = i_halt ? ST_HALT : ST_RUN;
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_RUN;
            r_pc         <= RESET_PC;
            r_cond       <= '0;
            r_target     <= '0;
            r_flags      <= '0;
            r_jump_taken <= 1'b0;
            r_cond_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_jump_taken <= w_taken_nxt;
            r_cond_err   <= w_err_nxt;
            if (w_capture) begin
                r_cond   <= i_jump_cond;
                r_target <= i_jump_target;
                r_flags  <= w_eff_flags;
            end
        end
    end

    assign o_pc_out     = r_pc;
    assign o_jump_taken = r_jump_taken;
    assign o_cond_err   = r_cond_err;
    assign o_busy       = (r_state != ST_RUN);

endmodule

// File: tb/tb_branch_unit.sv
// Directed plus randomized bench for branch_unit, checked against a behavioural PC/jump model.
module tb_branch_unit;

    localparam int          ADDR_W = 12;
    localparam logic [11:0] RST_PC = 12'h010;

    logic              i_clk;
    logic              i_rst;
    logic              i_pc_en;
    logic              i_jump_req;
    logic [2:0]        i_jump_cond;
    logic [ADDR_W-1:0] i_jump_target;
    logic [1:0]        i_flags;
    logic              i_flag_write;
    logic [1:0]        i_flag_in;
    logic              i_halt;
    logic [ADDR_W-1:0] o_pc_out;
    logic              o_jump_taken;
    logic              o_cond_err;
    logic              o_busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [ADDR_W-1:0] m_pc;
    bit                m_halted;
    bit                m_pending;
    logic [2:0]        m_cond;
    logic [ADDR_W-1:0] m_tgt;
    logic [1:0]        m_fl;
    bit                m_jt;
    bit                m_ce;

    branch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RST_PC)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_pc_en       (i_pc_en),
        .i_jump_req    (i_jump_req),
        .i_jump_cond   (i_jump_cond),
        .i_jump_target (i_jump_target),
        .i_flags       (i_flags),
        .i_flag_write  (i_flag_write),
        .i_flag_in     (i_flag_in),
        .i_halt        (i_halt),
        .o_pc_out      (o_pc_out),
        .o_jump_taken  (o_jump_taken),
        .o_cond_err    (o_cond_err),
        .o_busy        (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Conditions 1..4 test flag (cond-1)/2 (0=Z, 1=C) against required value cond%2.
    function automatic bit ref_taken(input logic [2:0] c, input logic [1:0] fl);
        int ci;
        ci = int'(c);
        if (ci == 0) return 1'b1;
        return fl[(ci - 1) / 2] == bit'(ci % 2);
    endfunction

    task automatic model_step();
        if (i_rst) begin
            m_pc = RST_PC; m_halted = 0; m_pending = 0; m_jt = 0; m_ce = 0;
            return;
        end
        m_jt = 0;
        m_ce = 0;
        if (m_halted) begin
            // frozen
        end else if (m_pending) begin
            m_pending = 0;
            if (m_cond > 3'd4) m_ce = 1;
            else if (ref_taken(m_cond, m_fl)) begin
                m_jt = 1;
                m_pc = m_tgt;
            end
            if (i_halt) m_halted = 1;
        end else if (i_halt) begin
            m_halted = 1;
        end else if (i_jump_req) begin
            m_pending = 1;
            m_cond    = i_jump_cond;
            m_tgt     = i_jump_target;
            m_fl      = i_flag_write ? i_flag_in : i_flags;
        end else if (i_pc_en) begin
            m_pc = m_pc + 12'd1;
        end
    endtask

    task automatic step(input string tag);
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
        chk({tag, ".pc"},    32'(o_pc_out),     32'(m_pc));
        chk({tag, ".taken"}, 32'(o_jump_taken), 32'(m_jt));
        chk({tag, ".err"},   32'(o_cond_err),   32'(m_ce));
        chk({tag, ".busy"},  32'(o_busy),       32'(m_halted || m_pending));
    endtask

    task automatic idle_inputs();
        i_rst = 0; i_pc_en = 0; i_jump_req = 0; i_jump_cond = '0; i_jump_target = '0;
        i_flags = '0; i_flag_write = 0; i_flag_in = '0; i_halt = 0;
    endtask

    task automatic req(input logic [2:0] c, input logic [11:0] t);
        i_jump_req = 1; i_jump_cond = c; i_jump_target = t;
    endtask

    initial begin
        m_pc = '0; m_halted = 0; m_pending = 0; m_cond = '0; m_tgt = '0; m_fl = '0;
        m_jt = 0; m_ce = 0;
        idle_inputs();
        i_rst = 1;
        step("reset");
        chk("reset_pc_lit", 32'(o_pc_out), 32'h010);
        chk("reset_busy_lit", 32'(o_busy), 32'h0);

        // Plain increments
        idle_inputs();
        i_pc_en = 1;
        for (int i = 0; i < 5; i++) begin
            step("incr");
            chk("incr_lit", 32'(o_pc_out), 32'h011 + 32'(i));
        end

        // JZ taken on stored flags; pc_en in RESOLVE ignored
        idle_inputs();
        i_flags = 2'b01;
        req(3'b001, 12'h3A0);
        step("jz_req");
        chk("jz_busy_lit", 32'(o_busy), 32'h1);
        idle_inputs();
        i_pc_en = 1;
        step("jz_res");
        chk("jz_pc_lit", 32'(o_pc_out), 32'h3A0);
        chk("jz_taken_lit", 32'(o_jump_taken), 32'h1);
        idle_inputs();
        step("jz_after");

        // JC taken through the flag bypass
        i_flags = 2'b00; i_flag_write = 1; i_flag_in = 2'b10;
        req(3'b011, 12'h055);
        step("jc_req");
        idle_inputs();
        step("jc_res");
        chk("jc_bypass_lit", 32'(o_pc_out), 32'h055);

        // Wrap from 0xFFF, then illegal condition
        req(3'b000, 12'hFFF);
        step("jmp_req");
        idle_inputs();
        step("jmp_res");
        i_pc_en = 1;
        step("wrap");
        chk("wrap_lit", 32'(o_pc_out), 32'h000);
        idle_inputs();
        req(3'b110, 12'h123);
        step("ill_req");
        idle_inputs();
        step("ill_res");
        chk("ill_err_lit", 32'(o_cond_err), 32'h1);
        chk("ill_pc_lit", 32'(o_pc_out), 32'h000);
        step("ill_after");

        // Reset during RESOLVE discards the jump
        req(3'b100, 12'h0AB);
        step("jnc_req");
        idle_inputs();
        i_rst = 1;
        step("jnc_rst");
        chk("rst_mid_pc_lit", 32'(o_pc_out), 32'h010);
        idle_inputs();
        step("jnc_after");

        // Halt beats jump_req; frozen until reset
        i_halt = 1; i_pc_en = 1;
        req(3'b000, 12'h777);
        step("halt_enter");
        for (int i = 0; i < 20; i++) begin
            i_halt = 1'($urandom_range(0, 1));
            i_pc_en = 1;
            i_jump_req = 1'(i % 2);
            i_jump_cond = 3'b000;
            step("halt_hold");
            chk("halt_pc_lit", 32'(o_pc_out), 32'h010);
            chk("halt_busy_lit", 32'(o_busy), 32'h1);
        end
        idle_inputs();
        i_rst = 1;
        step("halt_rst");
        idle_inputs();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            i_rst         = ($urandom_range(0, 29) == 0);
            i_halt        = ($urandom_range(0, 39) == 0);
            i_jump_req    = ($urandom_range(0, 2) == 0);
            i_pc_en       = 1'($urandom_range(0, 1));
            i_jump_cond   = 3'($urandom_range(0, 7));
            i_jump_target = 12'($urandom);
            i_flags       = 2'($urandom_range(0, 3));
            i_flag_write  = 1'($urandom_range(0, 1));
            i_flag_in     = 2'($urandom_range(0, 3));
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
